// File: rtl/cdf_accumulate.sv
// cdf_accumulate
// Turns the per-bin histogram stream from the fetch stage into a cumulative
// distribution. Each accepted sample produces one tagged CDF word write at
// WRITE_BASE + bin index. The block also reports the first non-zero
// cumulative value (CdfMin) and the final sum (CdfTotal) for equalisation.
//
// Ports:
//   clock        in   rising-edge clock
//   reset_n      in   synchronous active-low reset
//   StartIn      in   sample-valid strobe from fetch
//   AccumIn      in   bin count (SUM_W bits)
//   WriteEnable  out  memory write strobe
//   WriteAddress out  WRITE_BASE + bin index
//   WriteBus     out  {zero pad, TAG, cumulative sum}
//   CdfMin       out  first non-zero cumulative value of the run
//   CdfTotal     out  final cumulative sum of the last completed run
//   Done         out  one-cycle completion pulse
module cdf_accumulate #(
  parameter int          BINS       = 256,
  parameter logic [15:0] WRITE_BASE = 16'h4000,
  parameter int          SUM_W      = 20,
  parameter logic [15:0] TAG        = 16'hAAAA
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             StartIn,
  input  logic [SUM_W-1:0] AccumIn,
  output logic             WriteEnable,
  output logic [15:0]      WriteAddress,
  output logic [127:0]     WriteBus,
  output logic [SUM_W-1:0] CdfMin,
  output logic [SUM_W-1:0] CdfTotal,
  output logic             Done
);

  localparam int PAD_W = 128 - 16 - SUM_W;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Saturating add: clamp to all ones instead of wrapping.
  function automatic logic [SUM_W-1:0] sat_add(input logic [SUM_W-1:0] a,
                                                input logic [SUM_W-1:0] b);
    logic [SUM_W:0] full;
    full = {1'b0, a} + {1'b0, b};
    if (full[SUM_W]) begin
      sat_add = {SUM_W{1'b1}};
    end else begin
      sat_add = full[SUM_W-1:0];
    end
  endfunction

  state_t             state_q, state_d;
  logic [SUM_W-1:0]   sum_q, sum_d;
  logic [8:0]         idx_q, idx_d;
  logic               min_found_q, min_found_d;
  // High only during the first cycle spent in DONE, so Done pulses once
  // even when StartIn is held beyond the last bin.
  logic               enter_q, enter_d;
  logic               we_q, we_d;
  logic [15:0]        addr_q, addr_d;
  logic [127:0]       bus_q, bus_d;
  logic [SUM_W-1:0]   cdf_min_q, cdf_min_d;
  logic [SUM_W-1:0]   total_q, total_d;
  logic               done_q, done_d;

  logic               accept_s;
  logic               last_s;
  logic [SUM_W-1:0]   new_sum_s;

  // Next-state and registered-output logic.
  always_comb begin
    state_d     = state_q;
    sum_d       = sum_q;
    idx_d       = idx_q;
    min_found_d = min_found_q;
    enter_d     = 1'b0;
    we_d        = 1'b0;
    addr_d      = addr_q;
    bus_d       = bus_q;
    cdf_min_d   = cdf_min_q;
    total_d     = total_q;
    done_d      = 1'b0;
    accept_s    = 1'b0;
    new_sum_s   = sat_add(sum_q, AccumIn);
    last_s      = (idx_q == 9'(BINS - 1));

    case (state_q)
      IDLE: begin
        if (StartIn) begin
          accept_s  = 1'b1;
          // Cleared here; a non-zero first bin overrides it below.
          cdf_min_d = {SUM_W{1'b0}};
          if (last_s) begin
            state_d = DONE;
            enter_d = 1'b1;
          end else begin
            state_d = ACCUM;
          end
        end else begin
          state_d = IDLE;
        end
      end
      ACCUM: begin
        if (StartIn) begin
          accept_s = 1'b1;
          if (last_s) begin
            state_d = DONE;
            enter_d = 1'b1;
          end else begin
            state_d = ACCUM;
          end
        end else begin
          // Abort: discard the partial run, CdfTotal untouched.
          state_d     = IDLE;
          sum_d       = {SUM_W{1'b0}};
          idx_d       = 9'd0;
          min_found_d = 1'b0;
        end
      end
      DONE: begin
        if (enter_q) begin
          done_d  = 1'b1;
          total_d = sum_q;
        end else begin
          done_d  = 1'b0;
        end
        if (!StartIn) begin
          state_d     = IDLE;
          sum_d       = {SUM_W{1'b0}};
          idx_d       = 9'd0;
          min_found_d = 1'b0;
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        state_d     = IDLE;
        sum_d       = {SUM_W{1'b0}};
        idx_d       = 9'd0;
        min_found_d = 1'b0;
      end
    endcase

    if (accept_s) begin
      we_d   = 1'b1;
      addr_d = WRITE_BASE + 16'(idx_q);
      bus_d  = {{PAD_W{1'b0}}, TAG, new_sum_s};
      sum_d  = new_sum_s;
      idx_d  = idx_q + 9'd1;
      if (!min_found_q && (new_sum_s != {SUM_W{1'b0}})) begin
        cdf_min_d   = new_sum_s;
        min_found_d = 1'b1;
      end else begin
        min_found_d = min_found_q;
      end
    end else begin
      we_d = 1'b0;
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      sum_q       <= {SUM_W{1'b0}};
      idx_q       <= 9'd0;
      min_found_q <= 1'b0;
      enter_q     <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= 16'd0;
      bus_q       <= 128'd0;
      cdf_min_q   <= {SUM_W{1'b0}};
      total_q     <= {SUM_W{1'b0}};
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      sum_q       <= sum_d;
      idx_q       <= idx_d;
      min_found_q <= min_found_d;
      enter_q     <= enter_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      bus_q       <= bus_d;
      cdf_min_q   <= cdf_min_d;
      total_q     <= total_d;
      done_q      <= done_d;
    end
  end

  assign WriteEnable  = we_q;
  assign WriteAddress = addr_q;
  assign WriteBus     = bus_q;
  assign CdfMin       = cdf_min_q;
  assign CdfTotal     = total_q;
  assign Done         = done_q;

endmodule
